// File: rtl/rv_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// the hard-wired zero register and the two-requester identifier.
package rv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e r);
    return (r == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready requesters plus the register-file write port.
interface regfile_wb_arbiter_if
  import rv_pkg::*;
#(
  parameter int DW = rv_pkg::DATA_WIDTH,
  parameter int AW = rv_pkg::ADDR_WIDTH
);

  logic          a_valid;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          write_enable;
  logic [AW-1:0] rd;
  logic [DW-1:0] write_data;
  logic          contended;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, write_enable, rd, write_data, contended
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, write_enable, rd, write_data, contended
  );

endinterface

// File: rtl/register_file.sv
// Register file with x0 hard-wired to zero, one write port and one
// combinational read port.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] rs,
  output logic [DATA_WIDTH-1:0] rs_data
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (rd != '0)) begin
      regs[rd] <= write_data;
    end
  end

  assign rs_data = (rs == '0) ? '0 : regs[rs];

endmodule

// File: rtl/rr_burst_arbiter.sv
// Two-way round-robin arbiter that lets the last winner keep the grant for up
// to MAX_BURST consecutive contested cycles before handing over.
module rr_burst_arbiter
  import rv_pkg::*;
#(
  parameter int MAX_BURST = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  req_id_e          last_reg, last_next;
  logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  req_id_e          winner;
  logic             any_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg      <= REQ_A;
      burst_cnt_reg <= '0;
    end else begin
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    winner         = last_reg;
    any_req        = !rst && (req_a || req_b);

    if (!rst) begin
      if (req_a && req_b) begin
        // The counter never exceeds MAX_BURST: reaching it forces a handover.
        winner = (burst_cnt_reg < CNT_W'(MAX_BURST)) ? last_reg : other_req(last_reg);
        if (winner == last_reg) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end else begin
          last_next      = winner;
          burst_cnt_next = CNT_W'(1);
        end
      end else if (req_a || req_b) begin
        winner         = req_a ? REQ_A : REQ_B;
        last_next      = winner;
        burst_cnt_next = '0;
      end
    end

    gnt_a = any_req && (winner == REQ_A);
    gnt_b = any_req && (winner == REQ_B);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU (A) and the
// load/store (B) writeback paths; x0 writes are consumed but never issued.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = rv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rv_pkg::ADDR_WIDTH,
  parameter int MAX_BURST  = 2
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);

  logic                  gnt_a, gnt_b, xfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] rd_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  contended_reg;

  rr_burst_arbiter #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_a(bus.a_valid),
    .req_b(bus.b_valid),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b)
  );

  always_comb begin
    xfer     = gnt_a || gnt_b;
    sel_rd   = gnt_b ? bus.b_rd : bus.a_rd;
    sel_data = gnt_b ? bus.b_data : bus.a_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg        <= 1'b0;
      rd_reg        <= '0;
      data_reg      <= '0;
      contended_reg <= 1'b0;
    end else begin
      we_reg        <= xfer && (sel_rd != ADDR_WIDTH'(REG_ZERO));
      contended_reg <= bus.a_valid && bus.b_valid;
      if (xfer) begin
        rd_reg   <= sel_rd;
        data_reg <= sel_data;
      end
    end
  end

  assign bus.a_ready    = gnt_a;
  assign bus.b_ready    = gnt_b;
  // A write still in flight when reset arrives must not reach the register file.
  assign bus.write_enable = we_reg && !rst;
  assign bus.rd           = rd_reg;
  assign bus.write_data   = data_reg;
  assign bus.contended    = contended_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for `register_file`. Two writeback sources, an ALU path (A) and a load/store path (B), share the register file's single write port. The block arbitrates with bounded-burst round-robin, accepts requests over a valid/ready handshake, and drives `write_enable`/`rd`/`write_data` from a registered output stage. Writes to x0 are accepted and discarded, so the port never sees them.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of write data.
- `ADDR_WIDTH`, 5, register address width.
- `MAX_BURST`, 2, maximum consecutive contested grants to one requester (≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `a_valid`  in  1  requester A has a write pending.
- `a_rd`  in  ADDR_WIDTH  A destination register.
- `a_data`  in  DATA_WIDTH  A write data.
- `a_ready`  out  1  A request accepted this cycle.
- `b_valid`, `b_rd`, `b_data`, `b_ready`: same as A, for requester B.
- `write_enable`  out  1  to register file write enable.
- `rd`  out  ADDR_WIDTH  to register file destination.
- `write_data`  out  DATA_WIDTH  to register file data.
- `contended`  out  1  registered: both valid in the previous cycle.

## Operation
- Handshake: a transfer occurs on a rising edge where `x_valid && x_ready`.
  - A requester holds `valid`, `rd` and `data` stable until accepted.
  - `valid` never depends on `ready`.
- `a_ready`/`b_ready` are combinational from the valids and the arbiter state. At most one is high per cycle, and ready is never high without its valid.
- There is no backpressure from the register file, so one request is granted every cycle any valid is high.
- Arbiter state:
  - `last` (A/B): last granted requester.
  - `burst_cnt`: width clog2(MAX_BURST+1).
- Grant rule:
  - Only one valid: grant it.
  - Both valid: grant `last` if `burst_cnt < MAX_BURST`, else grant the other.
- State update on a grant to X:
  - Uncontested grant: `last<=X`, `burst_cnt<=0`.
  - Contested and X==last: `burst_cnt<=burst_cnt+1`.
  - Contested and X!=last: `last<=X`, `burst_cnt<=1`.
  - No grant: state unchanged.
- `MAX_BURST=1` gives strict alternation under contention.
- Starvation bound: a continuously valid requester waits at most `MAX_BURST` cycles.
- Output stage, on the edge of an accepted transfer:
  - `rd<=x_rd`, `write_data<=x_data`.
  - `write_enable<=(x_rd!=0)`.
- With no transfer, `write_enable<=0` and `rd`/`write_data` hold their previous values.
- An x0 write still raises `x_ready` (it is consumed), but produces no register-file write.

## Timing
- Reset values:
  - `write_enable=0`, `rd=0`, `write_data=0`, `contended=0`.
  - `last=A`, `burst_cnt=0`.
- `a_ready`/`b_ready` are 0 while `rst` is high.
- Latency:
  - Request accepted at edge N; `write_enable` is high during cycle N..N+1.
  - The register file commits at edge N+1.
  - A read of that register returns the new value from edge N+1.
- Throughput: 1 write per cycle.
- Reset mid-operation:
  - `rst` high at an edge overrides any transfer.
  - The output stage clears, so an in-flight write is dropped.
  - Requesters must re-present after `rst` falls.
- Simultaneous same `rd` from A and B: only the granted one is written this cycle. The other follows in a later cycle, so the later grant wins.

## Structure
- Shared package `rv_pkg`:
  - `DATA_WIDTH` and `ADDR_WIDTH` defaults.
  - Constant `REG_ZERO = 0`.
  - Requester-ID enum `{REQ_A, REQ_B}`.
- One natural sub-module: `rr_burst_arbiter`. It holds the 2-way grant logic plus `last`/`burst_cnt` state, and is reusable for read-port sharing later.
- `regfile_wb_arbiter` instantiates `rr_burst_arbiter` and adds the mux, x0 filter and output register.
- The bench instantiates `regfile_wb_arbiter` and `register_file` together.

## Test plan
- Reset, then A only: `a_rd=1`, `a_data=0xDEADBEEF`, one cycle.
  - `a_ready=1`; next cycle `write_enable=1`, `rd=1`.
  - Register-file read of x1 gives 0xDEADBEEF.
- Both valid continuously with `MAX_BURST=2`, from reset.
  - Grant sequence A,A,B,B,A,A.
  - `contended=1` from the second cycle.
- `MAX_BURST=1`, both valid for 4 cycles: grants A,B,A,B.
- B writes `rd=0`, `data=0xFFFFFFFF`.
  - `b_ready=1`; `write_enable` stays 0.
  - x0 reads 0.
- A and B both target x2 (A=0x11111111, B=0xCAFEBABE), `last=A`, `burst_cnt=0`.
  - A is written first, B next cycle; x2 ends at 0xCAFEBABE.
- A accepted at edge N with `rst=1` at edge N+1.
  - `write_enable=0` after N+1, target register unchanged.
  - Arbiter state back to `last=A`, `burst_cnt=0`.
